my_div: RTL and testbench
=========================

// Module: my_div
// PURPOSE
//   Multi-cycle radix-2 integer divider for MIPS DIV/DIVU; counterpart of the my_mul multiplier.
//   Computes quotient (LO) and remainder (HI) of a 32-bit dividend by a 32-bit divisor.
//   Sits beside my_mul in the execute stage. The pipeline starts it with valid and stalls on busy.
//   It can be killed by cancel on exception or flush.
// PARAMETERS
//   WIDTH   32   operand width; result is 2*WIDTH bits
// PORTS
//   clk      in   1         clock, rising edge
//   rst      in   1         asynchronous, active-low reset
//   a        in   WIDTH     dividend, sampled only in the acceptance cycle
//   b        in   WIDTH     divisor, sampled only in the acceptance cycle
//   sign     in   1         1: signed (DIV), 0: unsigned (DIVU); sampled with a/b
//   valid    in   1         start request
//   cancel   in   1         abort current operation
//   busy     out  1         high whenever state != IDLE
//   ready    out  1         one-cycle pulse: result valid
//   result   out  2*WIDTH   {remainder, quotient}; held until the next accepted start
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, counter=0, busy=0, ready=0, result=0.
//   FSM states: IDLE, DIV, DONE.
//     IDLE: if valid && !cancel -> latch operands, go to DIV, counter=0. This is the acceptance cycle.
//     DIV: one quotient bit per cycle for WIDTH cycles. After the cycle with counter==WIDTH-1, go to DONE.
//     DONE: ready=1 for exactly this cycle, result updated, then IDLE.
//       valid in DONE is ignored; a new op needs an IDLE cycle.
//   Latency: valid sampled in cycle N -> ready high in cycle N+WIDTH+1 (N+33 for WIDTH=32).
//   valid while busy: ignored, with no effect on the running operation.
//   cancel: in any state, next state IDLE; no ready pulse; result keeps its previous value.
//     cancel has priority over valid in the same cycle.
//   Operand latching: signed mode stores |a| and |b| as WIDTH-bit unsigned values.
//     Stores neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
//     |0x80000000| = 0x80000000, treated as unsigned.
//   Iteration: remainder register is WIDTH+1 bits.
//     Each step: shift in the next dividend bit, trial-subtract the divisor.
//     If non-negative, keep the difference and set the quotient bit to 1 (restoring).
//   Finalise: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (two's complement, WIDTH bits).
//   Divide by zero (b==0): quotient = all ones, remainder = a (raw operand, both modes).
//     Latency and handshake are unchanged.
//   Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//     No exception or flag is raised.
//   Remainder sign always follows the dividend; |remainder| < |divisor|.
// TESTING
//   T1 DIVU a=100, b=7, valid in cycle N -> busy=1 from N+1, ready=1 only in N+33, result={32'd2,32'd14}.
//   T2 DIV a=-7 (0xFFFFFFF9), b=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}; DIVU same operands -> {0x1, 0x7FFFFFFC}.
//   T3 DIV a=0x80000000, b=0xFFFFFFFF -> result={0x00000000, 0x80000000}; DIVU -> {0x80000000, 0x00000000}.
//   T4 a=0x12345678, b=0, sign=1 -> result={0x12345678, 0xFFFFFFFF}, ready at N+33.
//   T5 cancel at iteration 10 -> IDLE next cycle, no ready, result unchanged.
//     Then valid with 1000/10 -> {0, 100}. valid with busy=1 -> ignored.
//   T6 rst=0 mid-DIV (async, between edges) -> busy=0, ready=0, result=0 immediately.
//     After release, a new op completes correctly.

Source files
------------

// File: rtl/my_div_if.sv
// Execute-stage divider port bundle: start/cancel request from the pipeline,
// busy/ready/result back from the divider, plus the FSM state for observation.
interface my_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sign;
  logic               valid;
  logic               cancel;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;
  logic [1:0]         dbg_state;

  modport master (
    output a, b, sign, valid, cancel,
    input  busy, ready, result, dbg_state
  );

  modport slave (
    input  a, b, sign, valid, cancel,
    output busy, ready, result, dbg_state
  );
endinterface

// File: rtl/my_div.sv
// Multi-cycle restoring radix-2 divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} WIDTH+1 cycles after the start request is accepted.
module my_div #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  my_div_if.slave  bus
);

  // Handshake: a start is accepted only in IDLE when valid=1 and cancel=0;
  // busy stays high until the FSM is back in IDLE, ready pulses for one cycle
  // together with the new result, and cancel (priority over valid) aborts
  // silently leaving result untouched.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               dz_q;
  logic               busy_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;
  logic [2*WIDTH-1:0] result_d;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  // Dividend bits shift out of quo_q's top while quotient bits shift in at the bottom.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    q_bit     = ~rem_diff[WIDTH];
    rem_d     = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], q_bit};
    q_fin     = neg_q_q ? -quo_d : quo_d;
    r_fin     = neg_r_q ? -rem_d : rem_d;
    result_d  = dz_q ? {a_raw_q, {WIDTH{1'b1}}} : {r_fin, q_fin};
  end

  // The most negative value maps onto itself, which is exactly its unsigned magnitude.
  always_comb begin
    a_abs = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      a_raw_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.valid && !bus.cancel) begin
            state_q <= DIV;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            quo_q   <= a_abs;
            dvs_q   <= b_abs;
            rem_q   <= '0;
            a_raw_q <= bus.a;
            neg_q_q <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_q <= bus.sign & bus.a[WIDTH-1];
            dz_q    <= (bus.b == '0);
          end
        end
        DIV: begin
          if (bus.cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              result_q <= result_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_my_div.sv
// Directed bench for my_div: latency, signed/unsigned results, divide by zero,
// overflow, cancel, valid-while-busy and asynchronous reset mid-operation.
module tb_my_div;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;

  my_div_if #(.WIDTH(W)) bus ();

  my_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one operation, optionally pulsing a junk valid at cycle glitch_k while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] exp, input int glitch_k);
    int k;
    bit seen;
    logic [2*W-1:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sign = s; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0; bus.a = '0; bus.b = '0; bus.sign = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    k = 1;
    seen = 1'b0;
    while (k < LAT + 8 && !seen) begin
      if (bus.ready) begin
        seen = 1'b1;
      end else begin
        bus.valid = (k == glitch_k);
        bus.a     = 32'h0000_0003;
        bus.b     = 32'h0000_0001;
        @(negedge clk);
        bus.valid = 1'b0;
        k++;
      end
    end
    check({tag, "_lat"}, 64'(k), 64'(LAT));
    e = exp_q.pop_front();
    if (seen) begin
      check({tag, "_res"}, bus.result, e);
      last_res = e;
      @(negedge clk);
      check({tag, "_rdy_pulse"}, 64'(bus.ready), 64'd0);
      check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    int seen_ready;
    tests_run = 0;
    tests_failed = 0;
    last_res = '0;
    rst = 1'b0;
    bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.valid = 1'b0; bus.cancel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_res",   bus.result, 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    rst = 1'b1;

    // Directed vectors with hand-computed {remainder, quotient}
    run_op("t1_divu",   32'd100,       32'd7,         1'b0, {32'd2,         32'd14},        0);
    run_op("t2_div",    32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_op("t2_divu",   32'hFFFF_FFF9, 32'd2,         1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 0);
    run_op("t3_div",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 0);
    run_op("t3_divu",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 0);
    run_op("pos_neg",   32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0);
    run_op("neg_neg",   32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h0000_0003}, 0);
    run_op("max_by1",   32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 0);
    run_op("dz_neg",    32'hFFFF_FFF9, 32'd0,         1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0);
    run_op("t4_dz",     32'h1234_5678, 32'd0,         1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 0);

    // T5: cancel at iteration 10, no ready, result held
    @(negedge clk);
    bus.a = 32'd50; bus.b = 32'd3; bus.sign = 1'b0; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("t5_cancel_busy",  64'(bus.busy), 64'd0);
    check("t5_cancel_state", 64'(bus.dbg_state), 64'd0);
    seen_ready = 0;
    repeat (LAT + 5) begin
      if (bus.ready) seen_ready++;
      @(negedge clk);
    end
    check("t5_no_ready", 64'(seen_ready), 64'd0);
    check("t5_res_held", bus.result, last_res);

    // Cancel wins over valid in the same cycle
    bus.a = 32'd9; bus.b = 32'd2; bus.valid = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0; bus.cancel = 1'b0;
    check("t5_cancel_prio", 64'(bus.busy), 64'd0);

    run_op("t5_busy_valid", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 5);

    // T6: asynchronous reset between edges mid-operation
    @(negedge clk);
    bus.a = 32'd77; bus.b = 32'd5; bus.sign = 1'b0; bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("t6_busy",  64'(bus.busy), 64'd0);
    check("t6_ready", 64'(bus.ready), 64'd0);
    check("t6_res",   bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("t6_after", 32'd1000, 32'd7, 1'b0, {32'd6, 32'd142}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
